// File: rtl/traffic_phase_ctrl.sv
// Four-way intersection phase sequencer: green -> yellow -> all-red per direction,
// with request-driven direction selection and an emergency all-red hold.
module traffic_phase_ctrl #(
   parameter int GREEN_TICKS  = 5,
   parameter int YELLOW_TICKS = 2,
   parameter int ALLRED_TICKS = 1,
   parameter int SKIP_EMPTY   = 1,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic [3:0]  veh_req,
   input  logic        emerg,
   output logic [11:0] lights,
   output logic [1:0]  cur_dir,
   output logic [2:0]  phase,
   output logic        phase_start
);

   typedef enum logic [2:0] {
      PH_ALLRED     = 3'd0,
      PH_GREEN      = 3'd1,
      PH_YELLOW     = 3'd2,
      PH_EMERG_HOLD = 3'd3
   } phase_t;

   localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [11:0]      ALL_RED     = 12'b100_100_100_100;

   phase_t           state_q;
   phase_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [1:0]       dir_q;
   logic [1:0]       dir_d;
   logic [11:0]      lights_q;
   logic             phase_start_q;
   logic             tick_end;
   logic [1:0]       sel_dir;

   // First requesting direction after cur, wrapping back to cur itself last.
   function automatic logic [1:0] pick_dir(input logic [1:0] cur, input logic [3:0] req);
      logic [1:0] cand;
      logic [1:0] pick;
      logic       found;
      pick  = cur + 2'd1;
      found = 1'b0;
      if (SKIP_EMPTY != 0) begin
         for (int k = 1; k <= 4; k++) begin
            cand = cur + k[1:0];
            if (!found && req[cand]) begin
               pick  = cand;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

   function automatic logic [11:0] decode_lights(input phase_t ph, input logic [1:0] dir);
      logic [11:0] l;
      l = ALL_RED;
      case (ph)
         PH_GREEN:  l[3*dir +: 3] = 3'b001;
         PH_YELLOW: l[3*dir +: 3] = 3'b010;
         default:   l = ALL_RED;
      endcase
      return l;
   endfunction

   assign tick_end = tick && (cnt_q == '0);
   assign sel_dir  = pick_dir(dir_q, veh_req);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         PH_ALLRED: begin
            if (tick_end) begin
               if (emerg) begin
                  state_d = PH_EMERG_HOLD;
                  cnt_d   = '0;
               end else begin
                  state_d = PH_GREEN;
                  cnt_d   = GREEN_LOAD;
                  dir_d   = sel_dir;
               end
            end else if (tick) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PH_GREEN: begin
            // Emergency cuts green short immediately, whatever the tick is doing.
            if (emerg || tick_end) begin
               state_d = PH_YELLOW;
               cnt_d   = YELLOW_LOAD;
            end else if (tick) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PH_YELLOW: begin
            if (tick_end) begin
               state_d = PH_ALLRED;
               cnt_d   = ALLRED_LOAD;
            end else if (tick) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PH_EMERG_HOLD: begin
            if (!emerg) begin
               state_d = PH_ALLRED;
               cnt_d   = ALLRED_LOAD;
            end
         end
         default: begin
            state_d = PH_ALLRED;
            cnt_d   = ALLRED_LOAD;
         end
      endcase
   end

   // Lights and phase_start are computed from the next state so they stay registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= PH_ALLRED;
         cnt_q         <= ALLRED_LOAD;
         dir_q         <= 2'd3;
         lights_q      <= ALL_RED;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dir_q         <= dir_d;
         lights_q      <= decode_lights(state_d, dir_d);
         phase_start_q <= (state_d != state_q);
      end
   end

   assign lights      = lights_q;
   assign cur_dir     = dir_q;
   assign phase       = state_q;
   assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a request-skipping and a strict-rotation instance
// run in lockstep; every phase change is checked against a queue of expected phases.
module tb_traffic_phase_ctrl;
   localparam int W = 27;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_auto = 1'b0;
   logic        tick_man = 1'b0;
   logic        tick_en = 1'b0;
   logic        emerg = 1'b0;
   logic [3:0]  veh_req = 4'b0000;
   logic        tick;

   logic [11:0] lights_m, lights_s;
   logic [1:0]  cur_dir_m, cur_dir_s;
   logic [2:0]  phase_m, phase_s;
   logic        ps_m, ps_s;

   int errors = 0;
   int checks = 0;
   int tick_total = 0;
   int last_total = 0;

   // entry = {ticks spent in the phase just left, phase, dir, strict dir, lights}
   logic [W-1:0] exp_q[$];

   assign tick = tick_auto | tick_man;

   traffic_phase_ctrl #(.SKIP_EMPTY(1)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .veh_req(veh_req), .emerg(emerg),
      .lights(lights_m), .cur_dir(cur_dir_m), .phase(phase_m), .phase_start(ps_m)
   );

   traffic_phase_ctrl #(.SKIP_EMPTY(0)) dut_strict (
      .clk(clk), .rst_n(rst_n), .tick(tick), .veh_req(veh_req), .emerg(emerg),
      .lights(lights_s), .cur_dir(cur_dir_s), .phase(phase_s), .phase_start(ps_s)
   );

   always #5 clk = ~clk;

   // Free-running tick: one pulse every 4 clocks while enabled.
   initial begin : tick_gen
      int div;
      div = 0;
      forever begin
         @(negedge clk);
         if (tick_en) begin
            div = (div + 1) % 4;
            tick_auto = (div == 3);
         end else begin
            div = 0;
            tick_auto = 1'b0;
         end
      end
   end

   always @(posedge clk) if (rst_n && tick) tick_total++;

   function automatic logic [11:0] exp_lights(input logic [2:0] ph, input logic [1:0] d);
      logic [11:0] l;
      l = 12'b100_100_100_100;
      if (ph == 3'd1) l[3*d +: 3] = 3'b001;
      else if (ph == 3'd2) l[3*d +: 3] = 3'b010;
      return l;
   endfunction

   function automatic int nonred(input logic [11:0] l);
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) if (l[3*i +: 3] != 3'b100) n++;
      return n;
   endfunction

   function automatic void push(input int dur, input logic [2:0] ph, input logic [1:0] d, input logic [1:0] sd);
      exp_q.push_back({8'(dur), ph, d, sd, exp_lights(ph, d)});
   endfunction

   // Scoreboard: pops one expectation per phase change of the skipping instance.
   initial begin : monitor
      logic [W-1:0] e;
      logic [7:0]   dur_act;
      logic [2:0]   e_ph;
      logic [1:0]   e_d, e_sd;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last_total = tick_total;
         end else if (ps_m) begin
            dur_act = 8'(tick_total - last_total);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: phase=%0d dir=%0d, no change expected", phase_m, cur_dir_m);
            end else begin
               e = exp_q.pop_front();
               e_ph = e[18:16]; e_d = e[15:14]; e_sd = e[13:12];
               checks += 7;
               if (phase_m !== e_ph) begin errors++; $display("FAIL sb_phase: got %0d want %0d", phase_m, e_ph); end
               if (cur_dir_m !== e_d) begin errors++; $display("FAIL sb_dir: got %0d want %0d", cur_dir_m, e_d); end
               if (lights_m !== e[11:0]) begin errors++; $display("FAIL sb_lights: got %b want %b", lights_m, e[11:0]); end
               if (dur_act !== e[26:19]) begin errors++; $display("FAIL sb_ticks: phase %0d left after %0d ticks, want %0d", e_ph, dur_act, e[26:19]); end
               if (phase_s !== e_ph || ps_s !== 1'b1) begin errors++; $display("FAIL sb_strict_phase: got %0d/%b want %0d/1", phase_s, ps_s, e_ph); end
               if (cur_dir_s !== e_sd) begin errors++; $display("FAIL sb_strict_dir: got %0d want %0d", cur_dir_s, e_sd); end
               if (lights_s !== exp_lights(e_ph, e_sd)) begin errors++; $display("FAIL sb_strict_lights: got %b want %b", lights_s, exp_lights(e_ph, e_sd)); end
            end
            last_total = tick_total;
         end
      end
   end

   initial begin : safety
      forever begin
         @(negedge clk);
         checks++;
         assert (nonred(lights_m) <= 1 && nonred(lights_s) <= 1)
         else begin
            errors++;
            $display("FAIL one_nonred: lights %b / %b, want at most one non-red head", lights_m, lights_s);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_q(input int left);
      for (int c = 0; c < 3000 && exp_q.size() > left; c++) step();
   endtask

   task automatic wait_ticks(input int n);
      int t0;
      t0 = tick_total;
      for (int c = 0; c < 200 && tick_total < t0 + n; c++) step();
   endtask

   task automatic test_reset();
      repeat (3) step();
      checks += 4;
      if (phase_m !== 3'd0) begin errors++; $display("FAIL rst_phase: got %0d want 0", phase_m); end
      if (cur_dir_m !== 2'd3) begin errors++; $display("FAIL rst_dir: got %0d want 3", cur_dir_m); end
      if (lights_m !== 12'b100_100_100_100) begin errors++; $display("FAIL rst_lights: got %b want 100100100100", lights_m); end
      if (ps_m !== 1'b0) begin errors++; $display("FAIL rst_phase_start: got %b want 0", ps_m); end
      rst_n = 1'b1;
      repeat (2) step();
      checks += 2;
      if (phase_m !== 3'd0 || cur_dir_m !== 2'd3 || ps_m !== 1'b0) begin
         errors++; $display("FAIL rst_idle: phase=%0d dir=%0d ps=%b want 0/3/0", phase_m, cur_dir_m, ps_m);
      end
      if (phase_s !== 3'd0 || cur_dir_s !== 2'd3 || lights_s !== 12'b100_100_100_100) begin
         errors++; $display("FAIL rst_strict: phase=%0d dir=%0d lights=%b", phase_s, cur_dir_s, lights_s);
      end
   endtask

   task automatic test_rotation();
      push(1, 3'd1, 2'd0, 2'd0);
      for (int d = 0; d < 4; d++) begin
         push(5, 3'd2, 2'(d), 2'(d));
         push(2, 3'd0, 2'(d), 2'(d));
         push(1, 3'd1, 2'(d + 1), 2'(d + 1));
      end
      tick_en = 1'b1;
      wait_q(0);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL rotation_timeout: %0d pending, want 0", exp_q.size()); end
   endtask

   task automatic test_skip();
      logic [3:0] reqs [5];
      logic [1:0] dm [6];
      logic [1:0] ds [6];
      reqs = '{4'b1000, 4'b0000, 4'b0101, 4'b0001, 4'b0001};
      dm   = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0};
      ds   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 5; i++) begin
         veh_req = reqs[i];
         push(5, 3'd2, dm[i], ds[i]);
         push(2, 3'd0, dm[i], ds[i]);
         push(1, 3'd1, dm[i+1], ds[i+1]);
         wait_q(0);
         checks++;
         if (exp_q.size() != 0) begin errors++; $display("FAIL skip_timeout[%0d]: %0d pending, want 0", i, exp_q.size()); end
      end
      veh_req = 4'b0000;
   endtask

   task automatic test_emerg_green();
      push(5, 3'd2, 2'd0, 2'd1);
      push(2, 3'd0, 2'd0, 2'd1);
      push(1, 3'd1, 2'd1, 2'd2);
      push(1, 3'd2, 2'd1, 2'd2);
      push(2, 3'd0, 2'd1, 2'd2);
      push(1, 3'd3, 2'd1, 2'd2);
      push(3, 3'd0, 2'd1, 2'd2);
      push(1, 3'd1, 2'd2, 2'd3);
      wait_q(5);
      wait_ticks(1);
      emerg = 1'b1;
      wait_q(2);
      wait_ticks(3);
      checks += 2;
      if (phase_m !== 3'd3) begin errors++; $display("FAIL hold_phase: got %0d want 3", phase_m); end
      if (lights_m !== 12'b100_100_100_100) begin errors++; $display("FAIL hold_lights: got %b want 100100100100", lights_m); end
      emerg = 1'b0;
      wait_q(0);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL emerg_green_timeout: %0d pending, want 0", exp_q.size()); end
   endtask

   task automatic test_emerg_yellow();
      push(5, 3'd2, 2'd2, 2'd3);
      push(2, 3'd0, 2'd2, 2'd3);
      push(1, 3'd3, 2'd2, 2'd3);
      push(1, 3'd0, 2'd2, 2'd3);
      push(1, 3'd1, 2'd3, 2'd0);
      wait_q(4);
      emerg = 1'b1;
      wait_q(2);
      wait_ticks(1);
      emerg = 1'b0;
      wait_q(1);
      checks++;
      if (phase_m !== 3'd0) begin errors++; $display("FAIL pulse_setup: phase=%0d want 0", phase_m); end
      emerg = 1'b1;
      step();
      emerg = 1'b0;
      wait_q(0);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL emerg_yellow_timeout: %0d pending, want 0", exp_q.size()); end
   endtask

   task automatic test_tick_gaps();
      tick_en = 1'b0;
      repeat (100) step();
      checks += 2;
      if (phase_m !== 3'd1 || cur_dir_m !== 2'd3) begin errors++; $display("FAIL idle_hold: phase=%0d dir=%0d want 1/3", phase_m, cur_dir_m); end
      if (phase_s !== 3'd1 || cur_dir_s !== 2'd0) begin errors++; $display("FAIL idle_hold_strict: phase=%0d dir=%0d want 1/0", phase_s, cur_dir_s); end
      push(5, 3'd2, 2'd3, 2'd0);
      push(2, 3'd0, 2'd3, 2'd0);
      push(1, 3'd1, 2'd0, 2'd1);
      tick_man = 1'b1;
      repeat (8) step();
      tick_man = 1'b0;
      checks += 2;
      if (exp_q.size() != 0) begin errors++; $display("FAIL back_to_back_ticks: %0d pending, want 0", exp_q.size()); end
      if (phase_m !== 3'd1 || cur_dir_m !== 2'd0) begin errors++; $display("FAIL back_to_back_end: phase=%0d dir=%0d want 1/0", phase_m, cur_dir_m); end
   endtask

   task automatic test_async_reset();
      tick_en = 1'b1;
      push(5, 3'd2, 2'd0, 2'd1);
      push(2, 3'd0, 2'd0, 2'd1);
      push(1, 3'd1, 2'd1, 2'd2);
      push(5, 3'd2, 2'd1, 2'd2);
      push(2, 3'd0, 2'd1, 2'd2);
      push(1, 3'd1, 2'd2, 2'd3);
      push(5, 3'd2, 2'd2, 2'd3);
      wait_q(0);
      repeat (3) step();
      checks++;
      if (phase_m !== 3'd2 || cur_dir_m !== 2'd2) begin errors++; $display("FAIL pre_reset: phase=%0d dir=%0d want 2/2", phase_m, cur_dir_m); end
      #2;
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (lights_m !== 12'b100_100_100_100 || lights_s !== 12'b100_100_100_100) begin
         errors++; $display("FAIL async_lights: got %b / %b want all red", lights_m, lights_s);
      end
      if (phase_m !== 3'd0 || cur_dir_m !== 2'd3) begin errors++; $display("FAIL async_state: phase=%0d dir=%0d want 0/3", phase_m, cur_dir_m); end
      if (ps_m !== 1'b0) begin errors++; $display("FAIL async_phase_start: got %b want 0", ps_m); end
      tick_en = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      tick_en = 1'b1;
      push(1, 3'd1, 2'd0, 2'd0);
      push(5, 3'd2, 2'd0, 2'd0);
      push(2, 3'd0, 2'd0, 2'd0);
      push(1, 3'd1, 2'd1, 2'd1);
      wait_q(0);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL restart_timeout: %0d pending, want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_skip();
      test_emerg_green();
      test_emerg_yellow();
      test_tick_gaps();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Sequences the four approach signal heads of the 4-way intersection: round-robin green → yellow → all-red per direction.
- Phase durations are counted in ticks: single-cycle enable pulses on clk produced by the team's clock-divider block (configured as a pulse, not a toggled clock).
- Also arbitrates green between directions using vehicle-presence requests, and applies an emergency all-red override.

Parameters:
- GREEN_TICKS, 5, green duration in ticks (≥1)
- YELLOW_TICKS, 2, yellow duration in ticks (≥1)
- ALLRED_TICKS, 1, all-red clearance in ticks (≥1)
- SKIP_EMPTY, 1, 1 = skip directions with no request; 0 = strict rotation
- CNT_W, 8, phase counter width; every *_TICKS ≤ 2^CNT_W

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-clk-wide timing pulse, synchronous to clk
- veh_req  in  4  vehicle presence per direction, level, bit i = direction i
- emerg  in  1  emergency override request, level
- lights  out  12  direction i at bits [3i+2:3i] = {red, yellow, green}, one-hot per direction
- cur_dir  out  2  direction owning current/last green
- phase  out  3  0=ALLRED, 1=GREEN, 2=YELLOW, 3=EMERG_HOLD
- phase_start  out  1  one-clk pulse in the first cycle of every new phase

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered.
- Reset values:
  - phase=ALLRED, cur_dir=3, counter=ALLRED_TICKS-1.
  - lights=12'b100_100_100_100; phase_start=0.
  - The first green after reset therefore goes to direction 0 (subject to selection).
- Counter:
  - Loaded with N-1 on phase entry.
  - Decrements on each clk with tick=1.
  - When tick=1 and counter==0 the phase ends; the new phase is registered on the next clk edge.
  - A phase therefore spans exactly N ticks counted from entry.
  - tick is ignored in EMERG_HOLD.
- Lights per phase:
  - GREEN: cur_dir green, others red.
  - YELLOW: cur_dir yellow, others red.
  - ALLRED, EMERG_HOLD: all red.
  - No direction is ever green or yellow while another is non-red.
- Transitions:
  - GREEN → YELLOW at end of GREEN_TICKS.
  - GREEN → YELLOW on the next clk when emerg=1, counter reloaded. This takes priority over tick.
  - YELLOW → ALLRED at end of YELLOW_TICKS. emerg does not shorten yellow.
  - At end of ALLRED:
    - emerg=1 → EMERG_HOLD.
    - otherwise → GREEN with cur_dir = selected direction.
  - EMERG_HOLD → ALLRED (counter reloaded, cur_dir unchanged) on the first clk with emerg=0.
- Direction selection (sampled in the ending cycle of ALLRED):
  - Search cur_dir+1, +2, +3, +0 (mod 4) for the first veh_req bit set.
  - If SKIP_EMPTY=0, or veh_req=0, select cur_dir+1 mod 4.
  - cur_dir=3 wraps to 0.
- phase_start:
  - High for one clk after every registered phase change, including EMERG_HOLD entry/exit.
  - Low out of reset.
- Mid-operation rst_n assertion immediately forces the reset values, regardless of phase.

Test Plan:
1. Reset, SKIP_EMPTY=0, veh_req=0, tick every 4 clk → all red for 1 tick, then dir0 green 5 ticks, yellow 2 ticks, all-red 1 tick, then dir1 green; full cycle 0→1→2→3→0; phase_start pulses at each change.
2. SKIP_EMPTY=1, veh_req=4'b1000, start at cur_dir=0 → next green is dir3. Then veh_req=4'b0000 → dir0 (cur_dir+1 wraparound).
3. emerg raised in 2nd tick of dir1 green → yellow on next clk (2 ticks), all-red 1 tick, then EMERG_HOLD with lights=12'b100_100_100_100 while ticks continue; emerg dropped → ALLRED 1 tick, then dir2 green.
4. emerg raised during YELLOW → yellow lasts the full 2 ticks, then ALLRED, then EMERG_HOLD. emerg pulsed only during ALLRED but low at its end → normal green, no hold.
5. tick held low for 100 clk in GREEN → no state change. Single tick arriving in the same cycle as phase entry → counts as the first tick of that phase.
6. rst_n asserted asynchronously mid-YELLOW of dir2 → lights all red, phase=0, cur_dir=3 without waiting for a clk edge. Release → sequence restarts at dir0. Throughout all tests, check via assertion that at most one direction is ever non-red.
